// File: rtl/alu_sequencer.sv
// Single-issue controller in front of a 1-bit-shift 32-bit ALU.
// Iterates shifts, masks per-class flags and keeps the architectural {O,S,C,Z} register.
module alu_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [4:0]         req_op,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  input  logic               req_setf,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic [3:0]         rsp_flags,
  output logic               rsp_err,
  output logic [3:0]         flags_o,
  output logic [4:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [3:0]         alu_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  localparam logic [4:0] OP_ZERO  = 5'b10000;
  localparam logic [4:0] OP_PASSA = 5'b10101;
  localparam logic [4:0] OP_LSL   = 5'b01000;
  localparam logic [4:0] OP_LSR   = 5'b01001;

  state_t               state_reg;
  logic [4:0]           op_reg;
  logic                 setf_reg;
  logic                 err_reg;
  logic [SHAMT_W-1:0]   count_reg;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_LSL) || (op == OP_LSR);
  endfunction

  function automatic logic is_unsup(input logic [4:0] op);
    return (op == 5'b00010) || (op == 5'b00111) || (op == 5'b01010) ||
           (op == 5'b01011) || (op == 5'b01111);
  endfunction

  // Flags are {O,S,C,Z}: logic-class ops drop C and O, shifts drop O.
  function automatic logic [3:0] mask_flags(input logic [4:0] op, input logic [3:0] f);
    if (op[4] || op == 5'b01100 || op == 5'b01101 || op == 5'b01110)
      return {1'b0, f[2], 1'b0, f[0]};
    else if (is_shift(op))
      return {1'b0, f[2:0]};
    else
      return f;
  endfunction

  assign req_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      op_reg     <= 5'd0;
      setf_reg   <= 1'b0;
      err_reg    <= 1'b0;
      count_reg  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 4'd0;
      rsp_err    <= 1'b0;
      flags_o    <= 4'd0;
      alu_op     <= OP_ZERO;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg   <= req_op;
            setf_reg <= req_setf;
            err_reg  <= is_unsup(req_op);
            // ALU drive is registered here so it is valid for the whole first busy cycle.
            if (is_shift(req_op) && req_shamt != '0) begin
              state_reg <= SHIFT;
              count_reg <= req_shamt;
              alu_op    <= req_op;
              alu_a     <= req_a;
              alu_b     <= req_b;
            end else begin
              state_reg <= EXEC;
              count_reg <= '0;
              if (is_unsup(req_op)) begin
                alu_op <= OP_ZERO;
                alu_a  <= '0;
                alu_b  <= '0;
              end else begin
                alu_op <= is_shift(req_op) ? OP_PASSA : req_op;
                alu_a  <= req_a;
                alu_b  <= req_b;
              end
            end
          end
        end

        EXEC: begin
          // Masking by the driven op makes a zero-count shift behave as passa.
          rsp_result <= err_reg ? '0 : alu_result;
          rsp_flags  <= err_reg ? 4'd0 : mask_flags(alu_op, alu_flags);
          rsp_err    <= err_reg;
          rsp_valid  <= 1'b1;
          if (setf_reg && !err_reg)
            flags_o <= mask_flags(alu_op, alu_flags);
          alu_op    <= OP_ZERO;
          alu_a     <= '0;
          alu_b     <= '0;
          state_reg <= RESP;
        end

        SHIFT: begin
          alu_a     <= alu_result;
          count_reg <= count_reg - SHAMT_W'(1);
          if (count_reg == SHAMT_W'(1)) begin
            rsp_result <= alu_result;
            rsp_flags  <= mask_flags(op_reg, alu_flags);
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            if (setf_reg)
              flags_o <= mask_flags(op_reg, alu_flags);
            alu_op    <= OP_ZERO;
            alu_a     <= '0;
            alu_b     <= '0;
            state_reg <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU and
// a reference model that computes whole shifts directly rather than step by step.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_shamt;
  logic        req_setf;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  flags_o;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [3:0]  alu_flags;

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] exp_flags_o = 4'd0;

  always #5 clk = ~clk;

  alu_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt), .req_setf(req_setf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .flags_o(flags_o),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  // Behavioural ALU: returns {O,S,C,Z, result}. C/O on logic ops are deliberately
  // noisy so that masking in the controller is exercised.
  function automatic logic [35:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, o;
    s = 33'd0;
    case (op)
      5'b00000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                      o = (a[31] == b[31]) && (r[31] != a[31]); end
      5'b00001: begin s = {1'b0, a} - {1'b0, b}; r = s[31:0]; c = s[32];
                      o = (a[31] != b[31]) && (r[31] != a[31]); end
      5'b01000: begin r = a << 1; c = a[31]; o = a[31] ^ a[30]; end
      5'b01001: begin r = a >> 1; c = a[0];  o = 1'b1; end
      5'b10000: begin r = 32'd0;  c = 1'b1;  o = 1'b1; end
      5'b10001: begin r = a & b;  c = 1'b1;  o = 1'b1; end
      5'b10101: begin r = a;      c = a[0];  o = 1'b1; end
      default:  begin r = a ^ (b + {27'd0, op}); c = r[1]; o = r[0]; end
    endcase
    return {o, r[31], c, (r == 32'd0), r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_model(alu_op, alu_a, alu_b);

  function automatic bit unsup(input logic [4:0] op);
    return op == 5'b00010 || op == 5'b00111 || op == 5'b01010 ||
           op == 5'b01011 || op == 5'b01111;
  endfunction

  // Reference: {err, flags, result} for a whole operation.
  function automatic logic [36:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
    logic [35:0] m;
    logic [31:0] r;
    logic c;
    int idx;
    if (unsup(op)) return {1'b1, 4'd0, 32'd0};
    if (op == 5'b01000 || op == 5'b01001) begin
      if (sh == 5'd0) begin
        r = a; c = 1'b0;
      end else if (op == 5'b01000) begin
        r = a << sh; idx = 32 - int'(sh); c = a[idx];
      end else begin
        r = a >> sh; idx = int'(sh) - 1; c = a[idx];
      end
      return {1'b0, 1'b0, r[31], c, (r == 32'd0), r};
    end
    m = alu_model(op, a, b);
    if (op[4] || op == 5'b01100 || op == 5'b01101 || op == 5'b01110)
      return {1'b0, 1'b0, m[34], 1'b0, m[32], m[31:0]};
    return {1'b0, m};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction; hold>0 stalls the response that many cycles while offering another request.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic setf, input int hold);
    logic [36:0] e;
    int lat;
    int exp_lat;
    logic [31:0] r0;
    logic [3:0]  f0;
    e = ref_model(op, a, b, sh);
    exp_lat = ((op == 5'b01000 || op == 5'b01001) && sh != 0) ? int'(sh) : 1;
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_shamt = sh; req_setf = setf; req_valid = 1'b1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid && lat < 100);
    // Edges after accept: accept cycle T, response visible in cycle T+1+lat.
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_err", 64'(rsp_err), 64'(e[36]));
    check("rsp_result", 64'(rsp_result), 64'(e[31:0]));
    if (!e[36]) check("rsp_flags", 64'(rsp_flags), 64'(e[35:32]));
    if (setf && !e[36]) exp_flags_o = e[35:32];
    check("flags_o", 64'(flags_o), 64'(exp_flags_o));
    $display("op=%b a=%h b=%h sh=%0d setf=%0d -> res=%h flags=%b err=%0d lat=%0d flags_o=%b",
             op, a, b, sh, setf, rsp_result, rsp_flags, rsp_err, lat, flags_o);
    if (hold > 0) begin
      r0 = rsp_result; f0 = rsp_flags;
      rsp_ready = 1'b0;
      req_op = 5'b00000; req_a = 32'd1; req_b = 32'd1; req_shamt = 5'd0; req_valid = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_result", 64'(rsp_result), 64'(r0));
        check("hold_flags", 64'(rsp_flags), 64'(f0));
        check("hold_ready", 64'(req_ready), 64'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("after_hold_idle", 64'(req_ready), 64'd1);
      check("after_hold_valid", 64'(rsp_valid), 64'd0);
    end else begin
      @(negedge clk);
      check("rsp_drop", 64'(rsp_valid), 64'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 5'd0; req_a = 32'd0; req_b = 32'd0; req_shamt = 5'd0; req_setf = 1'b0;
    #12;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_flags_o", 64'(flags_o), 64'd0);
    check("rst_alu_op", 64'(alu_op), 64'b10000);
    check("rst_alu_a", 64'(alu_a), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_op(5'b00000, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1, 0);
    check("t1_flags_o", 64'(flags_o), 64'b1100);
    do_op(5'b01000, 32'h80000001, 32'd0, 5'd4, 1'b0, 0);
    do_op(5'b01000, 32'h80000001, 32'd0, 5'd1, 1'b0, 0);
    do_op(5'b10001, 32'h0000F0F0, 32'h00000F0F, 5'd0, 1'b0, 0);
    do_op(5'b00010, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1'b1, 3);
    do_op(5'b01001, 32'hDEADBEEF, 32'd0, 5'd0, 1'b1, 0);
    do_op(5'b01001, 32'hFFFFFFFF, 32'd0, 5'd31, 1'b1, 0);
    do_op(5'b01000, 32'h00000001, 32'd0, 5'd31, 1'b1, 0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (i % 4 == 0) op = ($urandom_range(0, 1) != 0) ? 5'b01000 : 5'b01001;
      do_op(op, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            (i % 9 == 0) ? 2 : 0);
    end

    // Make sure the flag register is nonzero before aborting a shift with reset.
    do_op(5'b00000, 32'h7FFFFFFF, 32'd1, 5'd0, 1'b1, 0);
    @(negedge clk);
    req_op = 5'b01001; req_a = 32'hFFFFFFFF; req_shamt = 5'd31; req_setf = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    exp_flags_o = 4'd0;
    #2;
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_flags_o", 64'(flags_o), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_alu_op", 64'(alu_op), 64'b10000);
    $display("reset during shift: rsp_valid=%0d flags_o=%b req_ready=%0d",
             rsp_valid, flags_o, req_ready);
    @(negedge clk); rst_n = 1'b1;
    do_op(5'b00000, 32'd3, 32'd4, 5'd0, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
